// File: rtl/barrel_pixel_fetch.sv
// Frame-buffer read side of the barrel-distortion stream: coordinates in, raster-ordered
// pixels out, with producer back-pressure sized so the output FIFO can never overflow.
module barrel_pixel_fetch #(
    parameter int unsigned      H_RES      = 1080,
    parameter int unsigned      V_RES      = 960,
    parameter int unsigned      PIX_W      = 12,
    parameter int unsigned      ADDR_W     = 20,
    parameter int unsigned      RD_LAT     = 2,
    parameter int unsigned      FIFO_DEPTH = 16,
    parameter logic [PIX_W-1:0] FILL       = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       addr_x,
    input  logic [11:0]       addr_y,
    input  logic              addr_vld,
    output logic              mem_ready,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [PIX_W-1:0]  bram_dout,
    output logic [PIX_W-1:0]  pix_tdata,
    output logic              pix_tvalid,
    input  logic              pix_tready,
    output logic              pix_tuser,
    output logic              pix_tlast,
    output logic              frame_done,
    output logic [15:0]       oor_cnt,
    output logic              fifo_ovf
);
    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam int unsigned      X_W       = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned      Y_W       = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [11:0]      H_LIM     = 12'(H_RES);
    localparam logic [11:0]      V_LIM     = 12'(V_RES);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_RES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam int unsigned      READY_LIM = FIFO_DEPTH - 2;

    logic accept, in_range, fifo_wr, wr_ok, pop, empty, full;
    logic [ADDR_W-1:0] lin_addr, x_ext, y_ext;
    logic [PIX_W-1:0]  wr_data;
    int unsigned       reserved_next;

    logic              mem_ready_q, mem_ready_d;
    logic              bram_en_q, bram_en_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [RD_LAT:0]   vld_q, vld_d, oor_q, oor_d;
    logic [15:0]       oor_cnt_q, oor_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fifo_ovf_q, fifo_ovf_d;
    logic [X_W-1:0]    ox_q, ox_d;
    logic [Y_W-1:0]    oy_q, oy_d;
    logic              frame_done_q, frame_done_d;
    logic [PIX_W-1:0]  mem_q [FIFO_DEPTH];

    always_comb begin
        accept   = addr_vld & mem_ready_q;
        in_range = (addr_x < H_LIM) && (addr_y < V_LIM);
        x_ext    = ADDR_W'(addr_x);
        y_ext    = ADDR_W'(addr_y);
        // 1080 = 1024 + 32 + 16 + 8, so the row offset is four shifted copies of y
        if (H_RES == 1080) begin
            lin_addr = (y_ext << 10) + (y_ext << 5) + (y_ext << 4) + (y_ext << 3) + x_ext;
        end else begin
            lin_addr = y_ext * ADDR_W'(H_RES) + x_ext;
        end

        bram_en_d   = accept & in_range;
        bram_addr_d = bram_en_d ? lin_addr : bram_addr_q;
        oor_cnt_d   = oor_cnt_q;
        if (accept && !in_range && oor_cnt_q != 16'hFFFF) begin
            oor_cnt_d = oor_cnt_q + 16'd1;
        end

        // Out-of-range slots still occupy a pipeline position so output order is preserved
        vld_d = {vld_q[RD_LAT-1:0], accept};
        oor_d = {oor_q[RD_LAT-1:0], accept & ~in_range};

        empty      = (cnt_q == '0);
        full       = (cnt_q == DEPTH_C);
        pop        = ~empty & pix_tready;
        fifo_wr    = vld_q[RD_LAT];
        wr_data    = oor_q[RD_LAT] ? FILL : bram_dout;
        wr_ok      = fifo_wr & (~full | pop);
        wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_ovf_d = fifo_ovf_q | (fifo_wr & full & ~pop);
        case ({wr_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Count every slot that will need a FIFO entry, including the one just accepted
        reserved_next = 32'(cnt_d);
        for (int i = 0; i <= int'(RD_LAT); i++) begin
            reserved_next = reserved_next + 32'(vld_d[i]);
        end
        mem_ready_d = (reserved_next <= READY_LIM);

        ox_d         = ox_q;
        oy_d         = oy_q;
        frame_done_d = 1'b0;
        if (pop) begin
            if (ox_q == X_LAST) begin
                ox_d = '0;
                if (oy_q == Y_LAST) begin
                    oy_d         = '0;
                    frame_done_d = 1'b1;
                end else begin
                    oy_d = oy_q + 1'b1;
                end
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready_q  <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            vld_q        <= '0;
            oor_q        <= '0;
            oor_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            fifo_ovf_q   <= 1'b0;
            ox_q         <= '0;
            oy_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            mem_ready_q  <= mem_ready_d;
            bram_en_q    <= bram_en_d;
            bram_addr_q  <= bram_addr_d;
            vld_q        <= vld_d;
            oor_q        <= oor_d;
            oor_cnt_q    <= oor_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            fifo_ovf_q   <= fifo_ovf_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign mem_ready  = mem_ready_q;
    assign bram_en    = bram_en_q;
    assign bram_addr  = bram_addr_q;
    assign pix_tvalid = ~empty;
    assign pix_tdata  = empty ? '0 : mem_q[rd_ptr_q];
    assign pix_tuser  = ~empty & (ox_q == '0) & (oy_q == '0);
    assign pix_tlast  = ~empty & (ox_q == X_LAST);
    assign frame_done = frame_done_q;
    assign oor_cnt    = oor_cnt_q;
    assign fifo_ovf   = fifo_ovf_q;

endmodule

// File: tb/tb_barrel_pixel_fetch.sv
// Bench for barrel_pixel_fetch: directed vectors on a full-size instance plus random traffic
// against a queue-based reference model on full-size and small-frame instances.
module tb_barrel_pixel_fetch;
    localparam int          H      = 1080;
    localparam int          V      = 960;
    localparam int          D      = 16;
    localparam int          HS     = 6;
    localparam int          VS     = 3;
    localparam int          DS     = 8;
    localparam logic [11:0] FILL_S = 12'hABC;

    typedef struct {
        int          x;
        int          y;
        logic        en;
        int          addr;
        logic [11:0] pix;
        logic        user;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [11:0] ax, ay, bdout, bd1, tdata;
    logic        avld, mrdy, ben, tvalid, tready, tuser, tlast, fdone, ovf;
    logic [19:0] baddr;
    logic [15:0] oor;

    logic [11:0] ax_s, ay_s, bdout_s, bd1_s, tdata_s;
    logic        avld_s, mrdy_s, ben_s, tvalid_s, tready_s, tuser_s, tlast_s, fdone_s, ovf_s;
    logic [19:0] baddr_s;
    logic [15:0] oor_s;

    barrel_pixel_fetch dut (
        .clk(clk), .reset(reset), .addr_x(ax), .addr_y(ay), .addr_vld(avld),
        .mem_ready(mrdy), .bram_en(ben), .bram_addr(baddr), .bram_dout(bdout),
        .pix_tdata(tdata), .pix_tvalid(tvalid), .pix_tready(tready), .pix_tuser(tuser),
        .pix_tlast(tlast), .frame_done(fdone), .oor_cnt(oor), .fifo_ovf(ovf)
    );

    barrel_pixel_fetch #(
        .H_RES(HS), .V_RES(VS), .FIFO_DEPTH(DS), .FILL(FILL_S)
    ) dut_s (
        .clk(clk), .reset(reset), .addr_x(ax_s), .addr_y(ay_s), .addr_vld(avld_s),
        .mem_ready(mrdy_s), .bram_en(ben_s), .bram_addr(baddr_s), .bram_dout(bdout_s),
        .pix_tdata(tdata_s), .pix_tvalid(tvalid_s), .pix_tready(tready_s), .pix_tuser(tuser_s),
        .pix_tlast(tlast_s), .frame_done(fdone_s), .oor_cnt(oor_s), .fifo_ovf(ovf_s)
    );

    // Two-cycle BRAMs returning the low address bits; junk when not enabled
    always @(posedge clk) begin
        bd1     <= ben ? baddr[11:0] : 12'($urandom);
        bdout   <= bd1;
        bd1_s   <= ben_s ? baddr_s[11:0] : 12'($urandom);
        bdout_s <= bd1_s;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, one slot per instance
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int unsigned hs[2], exp_oor[2], users[2], lasts[2], fds[2];
    logic        fd_exp[2], stall[2], prev_u[2], prev_l[2];
    logic [11:0] prev_d[2];

    task automatic mon(input int id, input int hres, input int vres, input logic [11:0] fill,
                       input logic av, input logic mr, input logic [11:0] x, input logic [11:0] y,
                       input logic tv, input logic tr, input logic [11:0] td, input logic tu,
                       input logic tl, input logic fd);
        int unsigned f;
        int          a;
        int          sz;
        logic        inr;
        logic [11:0] e;
        f = hres * vres;
        if (reset) begin
            hs[id] = 0; exp_oor[id] = 0; users[id] = 0; lasts[id] = 0; fds[id] = 0;
            fd_exp[id] = 1'b0; stall[id] = 1'b0;
            if (id == 0) q0.delete(); else q1.delete();
            return;
        end
        if (fd || fd_exp[id]) check($sformatf("frame_done%0d", id), fd, fd_exp[id]);
        fd_exp[id] = 1'b0;
        if (fd) fds[id]++;
        if (stall[id]) begin
            check($sformatf("hold_valid%0d", id), tv, 1);
            check($sformatf("hold_data%0d", id), {tu, tl, td}, {prev_u[id], prev_l[id], prev_d[id]});
        end
        if (av && mr) begin
            inr = (int'(x) < hres) && (int'(y) < vres);
            a   = int'(y) * hres + int'(x);
            e   = inr ? a[11:0] : fill;
            if (id == 0) q0.push_back(e); else q1.push_back(e);
            if (!inr && exp_oor[id] < 65535) exp_oor[id]++;
        end
        if (tv && tr) begin
            sz = (id == 0) ? q0.size() : q1.size();
            check($sformatf("pixel_expected%0d", id), sz > 0, 1);
            if (sz > 0) begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("pix_data%0d", id), td, e);
            end
            check($sformatf("pix_tuser%0d", id), tu, (hs[id] % f) == 0);
            check($sformatf("pix_tlast%0d", id), tl, (hs[id] % hres) == hres - 1);
            fd_exp[id] = (hs[id] % f) == f - 1;
            if (tu) users[id]++;
            if (tl) lasts[id]++;
            hs[id]++;
        end
        stall[id]  = tv && !tr;
        prev_u[id] = tu;
        prev_l[id] = tl;
        prev_d[id] = td;
    endtask

    always @(negedge clk) begin
        mon(0, H, V, 12'h000, avld, mrdy, ax, ay, tvalid, tready, tdata, tuser, tlast, fdone);
        mon(1, HS, VS, FILL_S, avld_s, mrdy_s, ax_s, ay_s, tvalid_s, tready_s, tdata_s, tuser_s,
            tlast_s, fdone_s);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single coordinate with the FIFO empty and pix_tready high
    task automatic apply_vec(input vec_t v);
        check("vec_mem_ready", mrdy, 1);
        ax = 12'(v.x); ay = 12'(v.y); avld = 1'b1;
        step();
        avld = 1'b0;
        check("vec_bram_en", ben, v.en);
        if (v.en) check("vec_bram_addr", baddr, v.addr);
        step(); step();
        check("vec_early_valid", tvalid, 0);
        step();
        check("vec_valid", tvalid, 1);
        check("vec_data", tdata, v.pix);
        check("vec_tuser", tuser, v.user);
        check("vec_tlast", tlast, 0);
        step();
        check("vec_popped", tvalid, 0);
    endtask

    task automatic rand_coord(input int hres, input int vres, output logic [11:0] x,
                              output logic [11:0] y);
        x = ($urandom % 8 == 0) ? 12'($urandom % 4096) : 12'($urandom % hres);
        y = ($urandom % 8 == 0) ? 12'($urandom % 4096) : 12'($urandom % vres);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   acc;
        int   f_s;
        vecs[0] = '{x: 5,    y: 3,   en: 1'b1, addr: 3245,    pix: 12'hCAD, user: 1'b1};
        vecs[1] = '{x: 0,    y: 0,   en: 1'b1, addr: 0,       pix: 12'h000, user: 1'b0};
        vecs[2] = '{x: 1079, y: 959, en: 1'b1, addr: 1036799, pix: 12'h1FF, user: 1'b0};
        vecs[3] = '{x: 1080, y: 5,   en: 1'b0, addr: 0,       pix: 12'h000, user: 1'b0};
        vecs[4] = '{x: 4095, y: 0,   en: 1'b0, addr: 0,       pix: 12'h000, user: 1'b0};

        reset = 1'b1;
        avld = 1'b0; ax = '0; ay = '0; tready = 1'b0;
        avld_s = 1'b0; ax_s = '0; ay_s = '0; tready_s = 1'b0;
        repeat (3) step();
        check("rst_mem_ready", mrdy, 0);
        check("rst_bram_en", ben, 0);
        check("rst_bram_addr", baddr, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tuser", tuser, 0);
        check("rst_tlast", tlast, 0);
        check("rst_frame_done", fdone, 0);
        check("rst_oor_cnt", oor, 0);
        check("rst_fifo_ovf", ovf, 0);
        reset = 1'b0;
        step();
        check("mem_ready_after_reset", mrdy, 1);
        check("mem_ready_after_reset_s", mrdy_s, 1);

        tready = 1'b1;
        for (int i = 0; i < 5; i++) apply_vec(vecs[i]);
        check("oor_cnt_corners", oor, 2);

        // Back-pressure: producer keeps offering while the sink is stalled
        tready = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            avld = 1'b1;
            ax = 12'($urandom % H);
            ay = 12'($urandom % V);
            if (mrdy) acc++;
            step();
        end
        check("bp_accepts", acc, D - 1);
        check("bp_mem_ready_low", mrdy, 0);
        check("bp_fifo_ovf", ovf, 0);

        for (int i = 0; i < 600; i++) begin
            avld   = ($urandom % 4) != 0;
            tready = ($urandom % 3) != 0;
            rand_coord(H, V, ax, ay);
            avld_s   = ($urandom % 4) != 0;
            tready_s = ($urandom % 3) != 0;
            rand_coord(HS, VS, ax_s, ay_s);
            step();
        end
        avld = 1'b0; avld_s = 1'b0; tready = 1'b1; tready_s = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !tvalid && !tvalid_s) break;
            step();
        end
        repeat (3) step();
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        check("oor_cnt_random", oor, exp_oor[0]);
        check("oor_cnt_random_s", oor_s, exp_oor[1]);
        check("fifo_ovf_final", ovf, 0);
        check("fifo_ovf_final_s", ovf_s, 0);
        f_s = HS * VS;
        check("two_frames_seen_s", hs[1] >= 2 * f_s, 1);
        check("tuser_count_s", users[1], (hs[1] + f_s - 1) / f_s);
        check("tlast_count_s", lasts[1], hs[1] / HS);
        check("frame_done_count_s", fds[1], hs[1] / f_s);
        check("tuser_count", users[0], 1);

        // Reset with 10 pixels queued and 3 reads still in flight
        tready = 1'b0;
        acc = 0;
        for (int i = 0; i < 40 && acc < 13; i++) begin
            avld = 1'b1;
            ax = 12'($urandom % H);
            ay = 12'($urandom % V);
            if (mrdy) acc++;
            step();
        end
        avld = 1'b0;
        check("pre_reset_accepts", acc, 13);
        check("pre_reset_valid", tvalid, 1);
        reset = 1'b1;
        step(); step();
        check("in_reset_valid", tvalid, 0);
        reset = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_reset_idle", tvalid, 0);
        end
        apply_vec('{x: 9, y: 9, en: 1'b1, addr: 9729, pix: 12'h601, user: 1'b1});
        check("oor_cnt_after_reset", oor, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
